prog_mem_responder: RTL and testbench

Memory-side responder for the 8-bit microcontroller's control unit. It owns the 8-bit program counter, a 256x8 unified program/data RAM, and the fetch/data address multiplexing. It also provides a boot-load port that fills RAM over a valid/ready handshake before releasing the core. It sits between the control unit (bus initiator) and the top level, answering every fetch, LOAD and STORE the control unit issues.

---
 rtl/prog_mem_responder.sv | 119 +++++++++++
 tb/tb_prog_mem_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_responder.sv
// prog_mem_responder: program counter, 256x8 unified RAM and the boot loader
// that fills the RAM over a valid/ready port before releasing the core.
module prog_mem_responder #(
    parameter bit BOOT_EN  = 1'b1,
    parameter int BOOT_LEN = 256
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       pc_inc,
    input  logic       pc_load,
    input  logic [7:0] pc_next,
    input  logic       data_sel,
    input  logic [7:0] mem_addr,
    input  logic       mem_write_en,
    input  logic [7:0] mem_write_data,
    output logic [7:0] mem_read_data,
    output logic [7:0] pc,
    output logic       cpu_run,
    input  logic       prog_valid,
    input  logic [7:0] prog_data,
    output logic       prog_ready,
    output logic       boot_done
);

    typedef enum logic {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_t;

    localparam state_t     RST_STATE = BOOT_EN ? ST_BOOT : ST_RUN;
    // Pointer value of the final boot byte; BOOT_LEN=256 maps to 0xFF so the
    // pointer never needs to wrap.
    localparam logic [7:0] LAST_PTR  = 8'(BOOT_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] load_ptr_q, load_ptr_d;
    logic       boot_done_q, boot_done_d;
    logic       cpu_run_q, cpu_run_d;
    logic       prog_ready_q, prog_ready_d;

    logic [7:0] mem [256];
    logic       ram_we;
    logic [7:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic       boot_xfer;

    // Next-state, PC and RAM write-port selection.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        load_ptr_d   = load_ptr_q;
        boot_done_d  = boot_done_q;
        cpu_run_d    = cpu_run_q;
        prog_ready_d = prog_ready_q;
        ram_we       = 1'b0;
        ram_waddr    = mem_addr;
        ram_wdata    = mem_write_data;
        boot_xfer    = (state_q == ST_BOOT) && prog_valid;

        if (state_q == ST_BOOT) begin
            if (boot_xfer) begin
                ram_we     = 1'b1;
                ram_waddr  = load_ptr_q;
                ram_wdata  = prog_data;
                load_ptr_d = load_ptr_q + 8'd1;
                if (load_ptr_q == LAST_PTR) begin
                    // Outputs are registered, so the core sees cpu_run the
                    // cycle after the final accepting edge.
                    state_d      = ST_RUN;
                    boot_done_d  = 1'b1;
                    cpu_run_d    = 1'b1;
                    prog_ready_d = 1'b0;
                    load_ptr_d   = load_ptr_q;
                end
            end
        end else begin
            if (data_sel && mem_write_en) begin
                ram_we = 1'b1;
            end
            // Jump target takes priority over sequential advance.
            if (pc_load) begin
                pc_d = pc_next;
            end else if (pc_inc) begin
                pc_d = pc_q + 8'd1;
            end
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= RST_STATE;
            pc_q         <= 8'h00;
            load_ptr_q   <= 8'h00;
            boot_done_q  <= 1'b0;
            cpu_run_q    <= !BOOT_EN;
            prog_ready_q <= BOOT_EN;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            load_ptr_q   <= load_ptr_d;
            boot_done_q  <= boot_done_d;
            cpu_run_q    <= cpu_run_d;
            prog_ready_q <= prog_ready_d;
        end
    end

    // RAM storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    assign mem_read_data = mem[data_sel ? mem_addr : pc_q];
    assign pc            = pc_q;
    assign cpu_run       = cpu_run_q;
    assign prog_ready    = prog_ready_q;
    assign boot_done     = boot_done_q;

endmodule

// File: tb/tb_prog_mem_responder.sv
// Directed bench for prog_mem_responder: boot load, PC sequencing, CPU
// stores, resets mid-boot and mid-run, and a BOOT_EN=0 instance.
module tb_prog_mem_responder;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       pc_inc, pc_load, data_sel, mem_write_en, prog_valid;
    logic [7:0] pc_next, mem_addr, mem_write_data, prog_data;

    logic [7:0] rd1, pc1, rd0, pc0;
    logic       run1, rdy1, done1, run0, rdy0, done0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_mem_responder #(.BOOT_EN(1'b1), .BOOT_LEN(4)) u_dut (
        .clk(clk), .arst_n(arst_n), .pc_inc(pc_inc), .pc_load(pc_load),
        .pc_next(pc_next), .data_sel(data_sel), .mem_addr(mem_addr),
        .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
        .mem_read_data(rd1), .pc(pc1), .cpu_run(run1),
        .prog_valid(prog_valid), .prog_data(prog_data),
        .prog_ready(rdy1), .boot_done(done1)
    );

    prog_mem_responder #(.BOOT_EN(1'b0), .BOOT_LEN(4)) u_dut_run (
        .clk(clk), .arst_n(arst_n), .pc_inc(pc_inc), .pc_load(pc_load),
        .pc_next(pc_next), .data_sel(data_sel), .mem_addr(mem_addr),
        .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
        .mem_read_data(rd0), .pc(pc0), .cpu_run(run0),
        .prog_valid(prog_valid), .prog_data(prog_data),
        .prog_ready(rdy0), .boot_done(done0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic boot_byte(input logic [7:0] b);
        prog_valid = 1'b1;
        prog_data  = b;
        tick();
        prog_valid = 1'b0;
    endtask

    task automatic rd_at(input string tag, input logic [7:0] a, input logic [7:0] exp);
        data_sel = 1'b1;
        mem_addr = a;
        #1;
        chk(tag, rd1, exp);
    endtask

    task automatic store(input logic [7:0] a, input logic [7:0] d);
        data_sel       = 1'b1;
        mem_addr       = a;
        mem_write_data = d;
        mem_write_en   = 1'b1;
        tick();
        mem_write_en   = 1'b0;
    endtask

    initial begin
        arst_n = 1'b0; pc_inc = 0; pc_load = 0; pc_next = 0; data_sel = 0;
        mem_addr = 0; mem_write_en = 0; mem_write_data = 0;
        prog_valid = 0; prog_data = 0;
        tick(); tick();
        arst_n = 1'b1;
        #1;
        chk("rst_pc", pc1, 8'h00);
        chk("rst_cpu_run", run1, 1'b0);
        chk("rst_prog_ready", rdy1, 1'b1);
        chk("rst_boot_done", done1, 1'b0);
        chk("run_rst_cpu_run", run0, 1'b1);
        chk("run_rst_prog_ready", rdy0, 1'b0);

        // Partial boot, then reset: pointer must restart at 0.
        pc_inc = 1'b1;
        boot_byte(8'hAA);
        pc_inc = 1'b0;
        chk("boot_pc_hold", pc1, 8'h00);
        boot_byte(8'hBB);
        arst_n = 1'b0;
        #1;
        chk("midboot_rst_pc", pc1, 8'h00);
        chk("midboot_rst_cpu_run", run1, 1'b0);
        chk("midboot_rst_ready", rdy1, 1'b1);
        tick();
        arst_n = 1'b1;

        // Full boot with an idle cycle between the 2nd and 3rd byte.
        boot_byte(8'h11);
        boot_byte(8'h22);
        tick();
        boot_byte(8'h33);
        chk("boot3_cpu_run", run1, 1'b0);
        chk("boot3_done", done1, 1'b0);
        boot_byte(8'h44);
        chk("boot4_cpu_run", run1, 1'b1);
        chk("boot4_done", done1, 1'b1);
        chk("boot4_ready", rdy1, 1'b0);
        data_sel = 1'b0;
        #1;
        chk("first_fetch", rd1, 8'h11);
        rd_at("ram0", 8'h00, 8'h11);
        rd_at("ram1", 8'h01, 8'h22);
        rd_at("ram2", 8'h02, 8'h33);
        rd_at("ram3", 8'h03, 8'h44);

        // PC sequencing.
        data_sel = 1'b0;
        pc_inc = 1'b1;
        tick(); tick(); tick();
        pc_inc = 1'b0;
        chk("pc_inc3", pc1, 8'h03);
        chk("fetch_pc3", rd1, 8'h44);
        pc_load = 1'b1; pc_next = 8'hFF;
        tick();
        pc_load = 1'b0;
        chk("pc_load_ff", pc1, 8'hFF);
        pc_inc = 1'b1;
        tick();
        chk("pc_wrap", pc1, 8'h00);
        pc_load = 1'b1; pc_next = 8'h40;
        tick();
        pc_inc = 1'b0; pc_load = 1'b0;
        chk("pc_load_prio", pc1, 8'h40);
        tick();
        chk("pc_hold", pc1, 8'h40);

        // CPU stores and read-during-write.
        store(8'h80, 8'h3C);
        data_sel = 1'b1; mem_addr = 8'h80; mem_write_data = 8'hA5; mem_write_en = 1'b1;
        #1;
        chk("rdw_old", rd1, 8'h3C);
        tick();
        mem_write_en = 1'b0;
        chk("rdw_new", rd1, 8'hA5);
        data_sel = 1'b0; mem_addr = 8'h80; mem_write_data = 8'h5A; mem_write_en = 1'b1;
        tick();
        mem_write_en = 1'b0;
        rd_at("store_nosel", 8'h80, 8'hA5);
        chk("store_nosel_pc", pc1, 8'h40);

        // prog_valid in RUN must be ignored.
        store(8'h04, 8'h77);
        boot_byte(8'h55);
        rd_at("run_prog_ram4", 8'h04, 8'h77);
        rd_at("run_prog_ram0", 8'h00, 8'h11);
        chk("run_ready", rdy1, 1'b0);

        // BOOT_EN=0 instance ignores the boot port.
        store(8'h00, 8'h5A);
        boot_byte(8'h99);
        data_sel = 1'b1; mem_addr = 8'h00;
        #1;
        chk("noboot_ram0", rd0, 8'h5A);
        chk("noboot_done", done0, 1'b0);

        // Reset mid-RUN: PC clears, RAM survives.
        arst_n = 1'b0;
        mem_addr = 8'h80;
        #1;
        chk("runrst_pc", pc1, 8'h00);
        chk("runrst_cpu_run", run1, 1'b0);
        chk("runrst_ram", rd1, 8'hA5);
        chk("runrst_noboot_run", run0, 1'b1);
        tick();
        arst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
